// File: rtl/rtp_collect_pkg.sv
// Shared types and defaults for the RTP result collector.
package rtp_collect_pkg;

  // Run-control states of the collector.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_TMO   = 3'd4
  } rtp_state_e;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ID_W   = 32;
  localparam int DEF_DEPTH  = 8;

  // Result-entry layout in the default configuration; the collector
  // declares the same field order with its own parameter widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] hit_t;
    logic [DEF_ID_W-1:0]   ray_id;
    logic [0:0]            ch;
  } rtp_entry_t;

  // Width of a channel index; at least one bit even for a single channel.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rtp_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rtp_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_advance,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic             w_found;

  // Scan requesters starting at the pointer and grant the first one.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = IDX_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_ptr_nxt = (o_grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : o_grant_idx + IDX_W'(1);

  // Pointer moves past the winner only when a transfer actually happens.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/rtp_result_collector.sv
// Collects results from several RTP channels into one ordered stream and
// tracks run status (cycle budget, completion, result count).
module rtp_result_collector
  import rtp_collect_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [31:0]                 timeout_limit,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH*DATA_W-1:0]    ch_hitT,
  input  logic [NUM_CH*ID_W-1:0]      ch_ray_id,
  input  logic [NUM_CH-1:0]           ch_finish,
  output logic [NUM_CH-1:0]           ch_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_hitT,
  output logic [ID_W-1:0]             out_ray_id,
  output logic [ch_idx_w(NUM_CH)-1:0] out_ch,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout,
  output logic [63:0]                 cycle_count,
  output logic [31:0]                 result_count
);

  localparam int CH_W = ch_idx_w(NUM_CH);
  localparam int AW   = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] hit_t;
    logic [ID_W-1:0]   ray_id;
    logic [CH_W-1:0]   ch;
  } entry_t;

  rtp_state_e        r_state;
  rtp_state_e        w_state_nxt;
  logic [NUM_CH-1:0] r_fin;
  entry_t            r_mem [DEPTH];
  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic [AW:0]       w_wr_nxt;
  logic [AW:0]       w_rd_nxt;
  logic [AW:0]       w_cnt;
  logic [AW:0]       w_cnt_nxt;
  logic              w_full;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_tmo_hit;
  logic              w_counting;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_gidx;
  entry_t            w_push_entry;
  entry_t            w_head;
  logic              r_out_valid;
  entry_t            r_out;
  logic              r_busy;
  logic              r_done;
  logic              r_tmo;
  logic [63:0]       r_cycles;
  logic [31:0]       r_results;

  // Occupancy uses one extra pointer bit so full and empty are distinct.
  assign w_cnt  = r_wr - r_rd;
  assign w_full = (w_cnt == (AW+1)'(DEPTH));

  // A start outside an active run restarts everything and flushes the queue.
  assign w_flush = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_TMO));

  // Channels are only offered to the arbiter while running with space left;
  // a pop in the same cycle deliberately does not free a slot early.
  assign w_req  = ((r_state == ST_RUN) && !w_full) ? ch_valid : '0;
  assign w_push = |w_grant;
  assign w_pop  = r_out_valid && out_ready && !w_flush;

  rtp_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_req       (w_req),
    .i_advance   (w_push),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign w_push_entry.hit_t  = ch_hitT[int'(w_gidx)*DATA_W +: DATA_W];
  assign w_push_entry.ray_id = ch_ray_id[int'(w_gidx)*ID_W +: ID_W];
  assign w_push_entry.ch     = w_gidx;

  assign w_tmo_hit  = (timeout_limit != 32'd0) && (r_cycles >= {32'd0, timeout_limit});
  assign w_counting = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) &&
                      ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN));

  // Next-state decision; timeout outranks finishing in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_TMO: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        if (w_tmo_hit) begin
          w_state_nxt = ST_TMO;
        end else if ((&r_fin) && (ch_valid == '0)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_tmo_hit) begin
          w_state_nxt = ST_TMO;
        end else if (w_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Queue pointers after this edge and the entry that will sit at the head.
  // A push lands on the head slot only when it goes into an otherwise
  // empty queue, in which case the pushed data is forwarded.
  assign w_rd_nxt  = w_flush ? '0 : r_rd + (AW+1)'(w_pop);
  assign w_wr_nxt  = w_flush ? '0 : r_wr + (AW+1)'(w_push);
  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;
  assign w_head    = (w_push && (r_wr[AW-1:0] == w_rd_nxt[AW-1:0])) ?
                     w_push_entry : r_mem[w_rd_nxt[AW-1:0]];

  // State register and status flags decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done  <= (w_state_nxt == ST_DONE);
      r_tmo   <= (w_state_nxt == ST_TMO);
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= w_push_entry;
    end
  end

  // Queue pointers and the registered head presented on the output stream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_wr        <= w_wr_nxt;
      r_rd        <= w_rd_nxt;
      r_out_valid <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        r_out <= w_head;
      end
    end
  end

  // Run counters and sticky per-channel finish flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cycles  <= '0;
      r_results <= '0;
      r_fin     <= '0;
    end else if (w_flush) begin
      r_cycles  <= '0;
      r_results <= '0;
      r_fin     <= '0;
    end else begin
      if (w_counting && (r_cycles != '1)) begin
        r_cycles <= r_cycles + 64'd1;
      end
      if (w_push && (r_results != '1)) begin
        r_results <= r_results + 32'd1;
      end
      if (r_state == ST_RUN) begin
        r_fin <= r_fin | ch_finish;
      end
    end
  end

  assign ch_ready     = w_grant;
  assign out_valid    = r_out_valid;
  assign out_hitT     = r_out.hit_t;
  assign out_ray_id   = r_out.ray_id;
  assign out_ch       = r_out.ch;
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout      = r_tmo;
  assign cycle_count  = r_cycles;
  assign result_count = r_results;

endmodule

// File: tb/tb_rtp_result_collector.sv
// Randomized and directed bench for rtp_result_collector, checked against a
// queue-based behavioural model of the run/collect rules.
module tb_rtp_result_collector;

  localparam int NCH   = 2;
  localparam int DW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 8;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;
  localparam int M_TMO   = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [31:0]       timeout_limit;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_hitT;
  logic [NCH*IW-1:0] ch_ray_id;
  logic [NCH-1:0]    ch_finish;
  logic [NCH-1:0]    ch_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_hitT;
  logic [IW-1:0]     out_ray_id;
  logic [0:0]        out_ch;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [63:0]       cycle_count;
  logic [31:0]       result_count;

  rtp_result_collector #(
    .NUM_CH (NCH),
    .DATA_W (DW),
    .ID_W   (IW),
    .DEPTH  (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .timeout_limit (timeout_limit),
    .ch_valid      (ch_valid),
    .ch_hitT       (ch_hitT),
    .ch_ray_id     (ch_ray_id),
    .ch_finish     (ch_finish),
    .ch_ready      (ch_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_hitT      (out_hitT),
    .out_ray_id    (out_ray_id),
    .out_ch        (out_ch),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .cycle_count   (cycle_count),
    .result_count  (result_count)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] hit;
    logic [31:0] id;
    int          ch;
  } res_t;

  res_t        q[$];
  int          m_state;
  int          m_ptr;
  logic [63:0] m_cyc;
  logic [31:0] m_res;
  logic [1:0]  m_fin;
  logic        m_ov;
  logic [31:0] m_oh;
  logic [31:0] m_oi;
  int          m_oc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = M_IDLE;
    m_ptr   = 0;
    m_cyc   = 64'd0;
    m_res   = 32'd0;
    m_fin   = 2'b00;
    m_ov    = 1'b0;
    m_oh    = 32'd0;
    m_oi    = 32'd0;
    m_oc    = 0;
  endtask

  // Channel the collector should accept this cycle, or -1.
  function automatic int model_grant();
    if (m_state != M_RUN || q.size() >= DEPTH) return -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (ch_valid[c]) return c;
    end
    return -1;
  endfunction

  // Apply one rising edge to the model using the current inputs.
  task automatic model_edge(input int g);
    bit   flush;
    bit   pop;
    bit   tmo;
    bit   was_active;
    bit   now_active;
    int   ns;
    res_t e;
    flush = start && (m_state == M_IDLE || m_state == M_DONE || m_state == M_TMO);
    pop   = !flush && m_ov && out_ready;
    tmo   = (timeout_limit != 0) && (m_cyc >= 64'(timeout_limit));
    ns    = m_state;
    case (m_state)
      M_RUN:   if (tmo) ns = M_TMO; else if (m_fin == 2'b11 && ch_valid == 2'b00) ns = M_DRAIN;
      M_DRAIN: if (tmo) ns = M_TMO; else if (q.size() == 0) ns = M_DONE;
      default: if (start) ns = M_RUN;
    endcase
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      e.hit = ch_hitT[g*DW +: DW];
      e.id  = ch_ray_id[g*IW +: IW];
      e.ch  = g;
      q.push_back(e);
      m_ptr = (g + 1) % NCH;
      if (m_res != 32'hFFFF_FFFF) m_res++;
    end
    was_active = (m_state == M_RUN || m_state == M_DRAIN);
    now_active = (ns == M_RUN || ns == M_DRAIN);
    if (flush) begin
      q.delete();
      m_cyc = 64'd0;
      m_res = 32'd0;
      m_fin = 2'b00;
    end else begin
      if (was_active && now_active && m_cyc != 64'hFFFF_FFFF_FFFF_FFFF) m_cyc++;
      if (m_state == M_RUN) m_fin = m_fin | ch_finish;
    end
    m_state = ns;
    m_ov    = (q.size() > 0);
    if (m_ov) begin
      m_oh = q[0].hit;
      m_oi = q[0].id;
      m_oc = q[0].ch;
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_ov);
    check_eq("out_hitT", out_hitT, m_oh);
    check_eq("out_ray_id", out_ray_id, m_oi);
    check_eq("out_ch", out_ch, m_oc);
    check_eq("busy", busy, (m_state == M_RUN || m_state == M_DRAIN));
    check_eq("done", done, (m_state == M_DONE));
    check_eq("timeout", timeout, (m_state == M_TMO));
    check_eq("cycle_count", cycle_count, m_cyc);
    check_eq("result_count", result_count, m_res);
  endtask

  // One clock: inputs were set after the falling edge; returns at the next one.
  task automatic tick();
    int         g;
    logic [1:0] exp_rdy;
    #1;
    g       = model_grant();
    exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
    check_eq("ch_ready", ch_ready, exp_rdy);
    @(posedge clock);
    model_edge(g);
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    ch_valid = 2'b00;
    #1;
    model_reset();
    check_eq("rst_ch_ready", ch_ready, 2'b00);
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic set_ch(input int c, input logic [31:0] hit, input logic [31:0] id);
    ch_hitT[c*DW +: DW]   = hit;
    ch_ray_id[c*IW +: IW] = id;
  endtask

  initial begin
    int pops;
    reset_n       = 1'b0;
    start         = 1'b0;
    timeout_limit = 32'd0;
    ch_valid      = 2'b00;
    ch_hitT       = '0;
    ch_ray_id     = '0;
    ch_finish     = 2'b00;
    out_ready     = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Single result from channel 0.
    start = 1'b1;
    tick();
    start     = 1'b0;
    ch_valid  = 2'b01;
    out_ready = 1'b1;
    set_ch(0, 32'h3F80_0000, 32'd5);
    tick();
    ch_valid = 2'b00;
    check_eq("single_valid", out_valid, 1'b1);
    check_eq("single_hit", out_hitT, 32'h3F80_0000);
    check_eq("single_id", out_ray_id, 32'd5);
    check_eq("single_ch", out_ch, 1'b0);
    check_eq("single_cnt", result_count, 32'd1);
    tick();

    // Both channels contending: grants alternate from channel 0.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      ch_valid = 2'b11;
      set_ch(0, 32'hA0 + j, 32'd100 + j);
      set_ch(1, 32'hB0 + j, 32'd200 + j);
      tick();
      check_eq("rr_ch", out_ch, j % 2);
      check_eq("rr_hit", out_hitT, (j % 2 == 0) ? 32'hA0 + j : 32'hB0 + j);
    end
    ch_valid = 2'b00;
    tick();
    tick();

    // Back-pressure: only DEPTH of ten offers are taken, none lost afterwards.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ch_valid = 2'b01;
      set_ch(0, 32'h100 + i, 32'd300 + i);
      tick();
    end
    #1;
    check_eq("full_rdy", ch_ready, 2'b00);
    tick();
    check_eq("full_cnt", result_count, 32'd14);
    ch_valid  = 2'b00;
    out_ready = 1'b1;
    pops      = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) pops++;
      tick();
    end
    check_eq("drain_pops", pops, 8);
    check_eq("drain_empty", out_valid, 1'b0);

    // Finish with three entries queued: drain, then done with frozen count.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ch_valid = 2'b10;
      set_ch(1, 32'h200 + i, 32'd400 + i);
      tick();
    end
    ch_valid  = 2'b00;
    ch_finish = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    check_eq("drain_busy", busy, 1'b1);
    check_eq("drain_held", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("fin_done", done, 1'b1);
    ch_finish = 2'b00;
    for (int i = 0; i < 3; i++) tick();

    // Timeout at limit 20, then a run with timeout disabled.
    timeout_limit = 32'd20;
    start         = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && m_state != M_TMO; i++) tick();
    check_eq("tmo_flag", timeout, 1'b1);
    check_eq("tmo_cycles", cycle_count, 64'd20);
    timeout_limit = 32'd0;
    start         = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check_eq("no_tmo", timeout, 1'b0);
    check_eq("no_tmo_busy", busy, 1'b1);

    // Reset mid-run with four results queued.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_valid = 2'b10;
      set_ch(1, 32'h300 + i, 32'd500 + i);
      tick();
    end
    ch_valid = 2'b00;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_cycles", cycle_count, 64'd0);
    check_eq("rst_results", result_count, 32'd0);
    check_eq("rst_busy", busy, 1'b0);
    @(negedge clock);
    do_reset();

    // Randomized traffic, starts, finishes, budgets and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        ch_valid[c] = ($urandom_range(0, 99) < 50);
        set_ch(c, $urandom, $urandom);
        if ($urandom_range(0, 99) < 2) ch_finish[c] = 1'b1;
      end
      out_ready = ($urandom_range(0, 99) < 60);
      start     = ($urandom_range(0, 99) < 3);
      if (start) begin
        ch_finish     = 2'b00;
        timeout_limit = ($urandom_range(0, 9) < 3) ? 32'd0 : 32'($urandom_range(5, 80));
      end
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
